// File: rtl/dram_arbiter.sv
// Arbiter that shares one dram_control request port among NREQ requesters.
// Define DRAM_ARB_RR_EN for round-robin arbitration; the default is fixed priority.
module dram_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ-1:0]          req_wmask,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [ADDR_W-1:0]        m_addr,
  output logic                     m_wmask,
  output logic [DATA_W-1:0]        m_wdata,
  input  logic [DATA_W-1:0]        m_rdata,
  output logic [NREQ-1:0]          grant,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic             any_s;
  logic [IDX_W-1:0] winner_s;
  logic [NREQ-1:0]  win_onehot_s;

  // Index of the lowest set bit; callers guarantee at least one bit is set.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NREQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (v[j]) begin
        idx = IDX_W'(j);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

`ifdef DRAM_ARB_RR_EN
  logic [IDX_W-1:0]  rr_ptr_r;
  logic [2*NREQ-1:0] rot_s;
  logic [IDX_W-1:0]  off_s;
  logic [IDX_W:0]    sum_s;

  // Rotate the valids so rr_ptr sits at bit 0, then map the offset back.
  always_comb begin
    rot_s = {req_valid, req_valid} >> rr_ptr_r;
    off_s = lowest_set(rot_s[NREQ-1:0]);
    sum_s = {1'b0, rr_ptr_r} + {1'b0, off_s};
    if (sum_s >= (IDX_W+1)'(NREQ)) begin
      winner_s = IDX_W'(sum_s - (IDX_W+1)'(NREQ));
    end else begin
      winner_s = sum_s[IDX_W-1:0];
    end
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    winner_s = lowest_set(req_valid);
  end
`endif

  // Request presence and the winner's one-hot grant vector.
  always_comb begin
    any_s        = |req_valid;
    win_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      m_valid   <= 1'b0;
      m_addr    <= {ADDR_W{1'b0}};
      m_wmask   <= 1'b0;
      m_wdata   <= {DATA_W{1'b0}};
      req_ready <= {NREQ{1'b0}};
      req_rdata <= {DATA_W{1'b0}};
      grant     <= {NREQ{1'b0}};
      busy      <= 1'b0;
`ifdef DRAM_ARB_RR_EN
      rr_ptr_r  <= {IDX_W{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          req_ready <= {NREQ{1'b0}};
          if (any_s) begin
            state_r <= BUSY;
            m_valid <= 1'b1;
            m_addr  <= req_addr[int'(winner_s)*ADDR_W +: ADDR_W];
            m_wmask <= req_wmask[winner_s];
            m_wdata <= req_wdata[int'(winner_s)*DATA_W +: DATA_W];
            grant   <= win_onehot_s;
            busy    <= 1'b1;
`ifdef DRAM_ARB_RR_EN
            if (winner_s == IDX_W'(NREQ - 1)) begin
              rr_ptr_r <= {IDX_W{1'b0}};
            end else begin
              rr_ptr_r <= winner_s + {{(IDX_W-1){1'b0}}, 1'b1};
            end
`endif
          end else begin
            m_valid <= 1'b0;
            grant   <= {NREQ{1'b0}};
            busy    <= 1'b0;
          end
        end
        BUSY: begin
          if (m_ready) begin
            state_r   <= DONE;
            m_valid   <= 1'b0;
            req_ready <= grant;
            if (!m_wmask) begin
              req_rdata <= m_rdata;
            end else begin
              req_rdata <= req_rdata;
            end
          end else begin
            m_valid <= 1'b1;
          end
        end
        // One-cycle completion slot; requests are deliberately not sampled here.
        DONE: begin
          state_r   <= IDLE;
          grant     <= {NREQ{1'b0}};
          req_ready <= {NREQ{1'b0}};
          busy      <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          m_valid   <= 1'b0;
          grant     <= {NREQ{1'b0}};
          req_ready <= {NREQ{1'b0}};
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Randomised self-checking bench for dram_arbiter against a transaction-level model.
// The model follows DRAM_ARB_RR_EN the same way the design does.
module tb_dram_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 128;
`ifdef DRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rstn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_wmask;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      req_rdata;
  logic               m_valid;
  logic               m_ready;
  logic [AW-1:0]      m_addr;
  logic               m_wmask;
  logic [DW-1:0]      m_wdata;
  logic [DW-1:0]      m_rdata;
  logic [NREQ-1:0]    grant;
  logic               busy;

  always #5 clk = ~clk;

  dram_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_addr(req_addr), .req_wmask(req_wmask),
    .req_wdata(req_wdata), .req_ready(req_ready), .req_rdata(req_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wmask(m_wmask),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .grant(grant), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the transaction in flight and what the ports must show.
  int              owner;
  int              arb_edge;
  int              rr;
  int              n = 0;
  logic [NREQ-1:0] exp_grant, exp_ready;
  logic            exp_busy, exp_mvalid, exp_wm;
  logic [AW-1:0]   exp_addr;
  logic [DW-1:0]   exp_wd, exp_rd;

  // Stimulus knobs for the requester agents and the dram responder.
  logic [NREQ-1:0] pending;
  int              rate = 0, spur = 0, perturb = 0, delay = 2, cnt = 0;
  bit              rand_delay = 1'b0, fix_rd = 1'b1, record = 1'b0;
  logic [DW-1:0]   fix_val = '0;
  logic [NREQ-1:0] grant_log[$];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // First valid requester searching upward from start with wrap-around.
  function automatic int pick(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic model_reset();
    owner = -1; arb_edge = 0; rr = 0;
    exp_grant = '0; exp_ready = '0; exp_busy = 1'b0; exp_mvalid = 1'b0;
    exp_wm = 1'b0; exp_addr = '0; exp_wd = '0; exp_rd = '0;
  endtask

  task automatic check_all();
    check_eq("m_valid", m_valid, exp_mvalid);
    check_eq("grant", grant, exp_grant);
    check_eq("busy", busy, exp_busy);
    check_eq("req_ready", req_ready, exp_ready);
    check_eq("req_rdata", req_rdata, exp_rd);
    check_eq("m_addr", m_addr, exp_addr);
    check_eq("m_wmask", m_wmask, exp_wm);
    check_eq("m_wdata", m_wdata, exp_wd);
  endtask

  task automatic drive_next();
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        pending[i]   = 1'b0;
        req_valid[i] = 1'b0;
      end else if (!pending[i] && $urandom_range(0, 99) < rate) begin
        pending[i]             = 1'b1;
        req_valid[i]           = 1'b1;
        req_addr[i*AW +: AW]   = $urandom;
        req_wmask[i]           = 1'($urandom_range(0, 1));
        req_wdata[i*DW +: DW]  = rand128();
      end else if (pending[i] && owner == i && $urandom_range(0, 99) < perturb) begin
        req_addr[i*AW +: AW] = $urandom;
      end
    end
    if (m_valid) begin
      cnt++;
      m_ready = (cnt >= delay);
    end else begin
      cnt = 0;
      m_ready = ($urandom_range(0, 99) < spur);
      if (rand_delay) delay = $urandom_range(1, 5);
    end
    m_rdata = fix_rd ? fix_val : rand128();
  endtask

  // One clock: advance the model on what the edge sampled, compare, then drive.
  task automatic cycle();
    int w;
    @(posedge clk);
    #1;
    n++;
    exp_ready = '0;
    if (owner >= 0) begin
      if (m_ready) begin
        exp_ready  = exp_grant;
        if (!exp_wm) exp_rd = m_rdata;
        owner      = -1;
        arb_edge   = n + 2;
        exp_mvalid = 1'b0;
      end
    end else if (n >= arb_edge && |req_valid) begin
      w          = pick(req_valid, RR ? rr : 0);
      owner      = w;
      exp_grant  = '0;
      exp_grant[w] = 1'b1;
      exp_addr   = req_addr[w*AW +: AW];
      exp_wm     = req_wmask[w];
      exp_wd     = req_wdata[w*DW +: DW];
      exp_mvalid = 1'b1;
      exp_busy   = 1'b1;
      rr         = (w + 1) % NREQ;
      if (record) grant_log.push_back(grant);
    end else begin
      exp_grant  = '0;
      exp_busy   = 1'b0;
      exp_mvalid = 1'b0;
    end
    check_all();
    drive_next();
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) cycle();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic wm, input logic [DW-1:0] wd);
    pending[i]            = 1'b1;
    req_valid[i]          = 1'b1;
    req_addr[i*AW +: AW]  = a;
    req_wmask[i]          = wm;
    req_wdata[i*DW +: DW] = wd;
  endtask

  initial begin
    rstn = 1'b0; req_valid = '0; req_addr = '0; req_wmask = '0; req_wdata = '0;
    m_ready = 1'b0; m_rdata = '0; pending = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #1 rstn = 1'b1;

    // Contention: both requesters always valid, each answered after 2 cycles.
    rate = 100; delay = 2; record = 1'b1;
    set_req(0, 32'h1000, 1'b0, '0);
    set_req(1, 32'h2000, 1'b1, rand128());
    for (int c = 0; c < 40 && grant_log.size() < 4; c++) cycle();
    record = 1'b0;
    check_eq("contention_grants", 128'(grant_log.size() >= 4), 128'd1);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check_eq("contention_order", grant_log[k], (RR && (k % 2 == 1)) ? 2'b10 : 2'b01);
    rate = 0;
    run(20);

    // Single read with an address change on requester 0 while BUSY.
    delay = 4; fix_val = 128'hDEADBEEF;
    set_req(0, 32'h40, 1'b0, '0);
    run(2);
    req_addr[0 +: AW] = 32'h80;
    run(8);
    check_eq("read_rdata", req_rdata, 128'hDEADBEEF);

    // A write must leave the last read data in place.
    fix_val = 128'hA5;
    set_req(0, 32'h100, 1'b0, '0);
    run(10);
    fix_val = 128'hFFFF;
    set_req(1, 32'h200, 1'b1, 128'h12345678);
    run(10);
    check_eq("write_keeps_rdata", req_rdata, 128'hA5);

    // Spurious m_ready in IDLE and DONE.
    spur = 100;
    run(5);
    set_req(0, 32'h300, 1'b0, '0);
    run(12);
    spur = 0;

    // Reset while requester 1 is BUSY; requester 0 must win afterwards.
    delay = 50;
    set_req(1, 32'h400, 1'b0, '0);
    run(2);
    set_req(0, 32'h500, 1'b0, '0);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    cnt = 0; m_ready = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b1;
    delay = 3;
    cycle();
    check_eq("post_reset_grant", grant, 2'b01);
    run(15);

    // Random traffic.
    rate = 30; spur = 10; perturb = 20; rand_delay = 1'b1; fix_rd = 1'b0;
    run(400);
    rate = 0;
    run(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
